// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction-fetch front end.
package fetch_pkg;

  localparam int unsigned DefDataW      = 4;
  localparam int unsigned DefInstrBeats = 3;
  localparam int unsigned DefAddrW      = 10;
  localparam int unsigned DefResetPc    = 0;

  typedef enum logic [1:0] {
    StFetch,
    StIssue,
    StHalt
  } state_e;

  // Width of the beat index: max(1, clog2(beats)).
  function automatic int unsigned beat_width(input int unsigned beats);
    int unsigned w;
    w = $clog2(beats);
    if (w < 1) begin
      w = 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/fetch_assembler.sv
// Collects memory beats into a wide instruction word and tracks the beat index.
module fetch_assembler #(
  parameter int unsigned DATA_W      = 4,
  parameter int unsigned INSTR_BEATS = 3,
  parameter int unsigned BEAT_W      = 2
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          clear_i,
  input  logic                          we_i,
  input  logic [DATA_W-1:0]             wdata_i,
  output logic [BEAT_W-1:0]             beat_o,
  output logic                          last_o,
  output logic [INSTR_BEATS*DATA_W-1:0] word_o
);

  logic [INSTR_BEATS-1:0][DATA_W-1:0] slot_d, slot_q;
  logic [BEAT_W-1:0]                  beat_d, beat_q;

  assign last_o = (beat_q == BEAT_W'(INSTR_BEATS - 1));
  assign beat_o = beat_q;
  assign word_o = slot_q;

  always_comb begin
    slot_d = slot_q;
    beat_d = beat_q;
    if (clear_i) begin
      beat_d = '0;
    end else if (we_i) begin
      slot_d[beat_q] = wdata_i;
      beat_d         = last_o ? '0 : beat_q + BEAT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      slot_q <= '0;
      beat_q <= '0;
    end else begin
      slot_q <= slot_d;
      beat_q <= beat_d;
    end
  end

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch FSM: walks the pc, assembles beats, issues instructions, handles redirect and halt.
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter int unsigned DATA_W      = DefDataW,
  parameter int unsigned INSTR_BEATS = DefInstrBeats,
  parameter int unsigned ADDR_W      = DefAddrW,
  parameter int unsigned RESET_PC    = DefResetPc
) (
  input  logic                                  clk,
  input  logic                                  rst,
  output logic                                  mem_req,
  output logic [ADDR_W-1:0]                     mem_addr,
  output logic [beat_width(INSTR_BEATS)-1:0]    mem_beat,
  input  logic [DATA_W-1:0]                     mem_data,
  input  logic                                  mem_valid,
  output logic                                  instr_valid,
  input  logic                                  instr_ready,
  output logic [INSTR_BEATS*DATA_W-1:0]         instr_data,
  output logic [ADDR_W-1:0]                     instr_pc,
  input  logic                                  redirect_valid,
  input  logic [ADDR_W-1:0]                     redirect_pc,
  input  logic                                  halt_req,
  output logic                                  halted
);

  localparam int unsigned BeatW = beat_width(INSTR_BEATS);

  state_e            state_d, state_q;
  logic [ADDR_W-1:0] pc_d, pc_q;
  logic [ADDR_W-1:0] instr_pc_d, instr_pc_q;
  logic              mem_req_d, mem_req_q;
  logic              instr_valid_d, instr_valid_q;
  logic              halted_d, halted_q;
  logic              asm_we;
  logic              asm_last;

  fetch_assembler #(
    .DATA_W      (DATA_W),
    .INSTR_BEATS (INSTR_BEATS),
    .BEAT_W      (BeatW)
  ) u_assembler (
    .clk_i   (clk),
    .rst_i   (rst),
    .clear_i (redirect_valid),
    .we_i    (asm_we),
    .wdata_i (mem_data),
    .beat_o  (mem_beat),
    .last_o  (asm_last),
    .word_o  (instr_data)
  );

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    instr_pc_d = instr_pc_q;
    asm_we     = 1'b0;

    unique case (state_q)
      StFetch: begin
        if (mem_valid) begin
          asm_we = 1'b1;
          if (asm_last) begin
            instr_pc_d = pc_q;
            pc_d       = pc_q + ADDR_W'(1);
            state_d    = StIssue;
          end
        end
      end
      StIssue: begin
        if (instr_ready) begin
          state_d = halt_req ? StHalt : StFetch;
        end
      end
      StHalt: begin
        if (!halt_req) begin
          state_d = StFetch;
        end
      end
      default: state_d = StFetch;
    endcase

    // Redirect overrides everything; a beat arriving this cycle is dropped, and an
    // in-progress ISSUE handshake has already been taken by the consumer.
    if (redirect_valid) begin
      asm_we     = 1'b0;
      pc_d       = redirect_pc;
      instr_pc_d = instr_pc_q;
      state_d    = (state_q == StHalt && halt_req) ? StHalt : StFetch;
    end

    mem_req_d     = (state_d == StFetch);
    instr_valid_d = (state_d == StIssue);
    halted_d      = (state_d == StHalt);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StFetch;
      pc_q          <= ADDR_W'(RESET_PC);
      instr_pc_q    <= '0;
      mem_req_q     <= 1'b1;
      instr_valid_q <= 1'b0;
      halted_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      instr_pc_q    <= instr_pc_d;
      mem_req_q     <= mem_req_d;
      instr_valid_q <= instr_valid_d;
      halted_q      <= halted_d;
    end
  end

  assign mem_req     = mem_req_q;
  assign mem_addr    = pc_q;
  assign instr_valid = instr_valid_q;
  assign instr_pc    = instr_pc_q;
  assign halted      = halted_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: directed scenarios plus random traffic against a queue-based model.
module tb_fetch_sequencer;

  localparam int DATA_W = 4;
  localparam int BEATS  = 3;
  localparam int ADDR_W = 10;
  localparam int WORD_W = BEATS * DATA_W;

  localparam int MFetching   = 0;
  localparam int MPresenting = 1;
  localparam int MParked     = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic [1:0]        mem_beat;
  logic [DATA_W-1:0] mem_data;
  logic              mem_valid;
  logic              instr_valid;
  logic              instr_ready;
  logic [WORD_W-1:0] instr_data;
  logic [ADDR_W-1:0] instr_pc;
  logic              redirect_valid;
  logic [ADDR_W-1:0] redirect_pc;
  logic              halt_req;
  logic              halted;

  int n_checks = 0;
  int n_fail   = 0;
  bit checking = 1'b0;
  bit mem_hash = 1'b0;

  fetch_sequencer #(
    .DATA_W      (DATA_W),
    .INSTR_BEATS (BEATS),
    .ADDR_W      (ADDR_W),
    .RESET_PC    (0)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .mem_req        (mem_req),
    .mem_addr       (mem_addr),
    .mem_beat       (mem_beat),
    .mem_data       (mem_data),
    .mem_valid      (mem_valid),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr_data     (instr_data),
    .instr_pc       (instr_pc),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .halt_req       (halt_req),
    .halted         (halted)
  );

  always #5 clk = ~clk;

  // Program memory: beat+1 for the directed part, an address hash for random traffic.
  logic [31:0] hash;
  always_comb begin
    hash     = 32'(mem_addr) * 32'd13 + 32'(mem_beat) * 32'd7 + 32'd1;
    mem_data = mem_hash ? hash[DATA_W-1:0] : 4'(mem_beat) + 4'd1;
  end

  // Behavioural model: a list of collected beats, a pc, and what the front end is doing.
  int                m_mode = MFetching;
  int                m_pc   = 0;
  int                m_ipc  = 0;
  logic [WORD_W-1:0] m_word = '0;
  logic [DATA_W-1:0] m_beats[$];

  always @(posedge clk) begin
    if (rst) begin
      m_mode = MFetching;
      m_pc   = 0;
      m_ipc  = 0;
      m_beats.delete();
    end else if (redirect_valid) begin
      m_mode = (m_mode == MParked && halt_req) ? MParked : MFetching;
      m_pc   = int'(redirect_pc);
      m_beats.delete();
    end else begin
      case (m_mode)
        MFetching: begin
          if (mem_valid) begin
            m_beats.push_back(mem_data);
            if (m_beats.size() == BEATS) begin
              for (int i = 0; i < BEATS; i++) m_word[i*DATA_W +: DATA_W] = m_beats[i];
              m_ipc  = m_pc;
              m_pc   = (m_pc + 1) % (1 << ADDR_W);
              m_mode = MPresenting;
              m_beats.delete();
            end
          end
        end
        MPresenting: if (instr_ready) m_mode = halt_req ? MParked : MFetching;
        default:     if (!halt_req) m_mode = MFetching;
      endcase
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (checking) begin
      chk("mem_req", 64'(mem_req), 64'(m_mode == MFetching));
      chk("instr_valid", 64'(instr_valid), 64'(m_mode == MPresenting));
      chk("halted", 64'(halted), 64'(m_mode == MParked));
      if (m_mode == MFetching) begin
        chk("mem_addr", 64'(mem_addr), 64'(m_pc));
        chk("mem_beat", 64'(mem_beat), 64'(m_beats.size()));
      end
      if (m_mode == MPresenting) begin
        chk("instr_data", 64'(instr_data), 64'(m_word));
        chk("instr_pc", 64'(instr_pc), 64'(m_ipc));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    while (instr_valid !== 1'b1 && n < 60) begin
      step();
      n++;
    end
    n_checks++;
    if (instr_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL %s timeout: instr_valid=%b, expected 1", tag, instr_valid);
    end
  endtask

  initial begin
    rst            = 1'b1;
    mem_valid      = 1'b1;
    instr_ready    = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    halt_req       = 1'b0;
    step();
    checking = 1'b1;
    step();
    step();
    rst = 1'b0;

    // Cycle 1 after reset release: beat 0 of address 0.
    chk("rel_req", 64'(mem_req), 64'd1);
    chk("rel_addr", 64'(mem_addr), 64'd0);
    chk("rel_beat", 64'(mem_beat), 64'd0);
    repeat (3) step();
    chk("c4_valid", 64'(instr_valid), 64'd1);
    chk("c4_data", 64'(instr_data), 64'h321);
    chk("c4_pc", 64'(instr_pc), 64'd0);
    step();
    chk("c5_addr", 64'(mem_addr), 64'd1);
    chk("c5_beat", 64'(mem_beat), 64'd0);
    chk("c5_valid", 64'(instr_valid), 64'd0);

    // Wait states on beat 1, then a consumer stall of 5 cycles.
    instr_ready = 1'b0;
    step();
    mem_valid = 1'b0;
    step();
    step();
    chk("ws_beat", 64'(mem_beat), 64'd1);
    mem_valid = 1'b1;
    wait_valid("ws");
    chk("ws_data", 64'(instr_data), 64'h321);
    chk("ws_pc", 64'(instr_pc), 64'd1);
    repeat (5) step();
    chk("stall_data", 64'(instr_data), 64'h321);
    chk("stall_req", 64'(mem_req), 64'd0);
    instr_ready = 1'b1;
    step();
    chk("rdy_addr", 64'(mem_addr), 64'd2);

    // Jump to 7, then redirect away on its beat 1.
    redirect_valid = 1'b1;
    redirect_pc    = 10'd7;
    step();
    redirect_valid = 1'b0;
    chk("j7_addr", 64'(mem_addr), 64'd7);
    step();
    redirect_valid = 1'b1;
    redirect_pc    = 10'h3A5;
    step();
    redirect_valid = 1'b0;
    chk("rd_addr", 64'(mem_addr), 64'h3A5);
    chk("rd_beat", 64'(mem_beat), 64'd0);
    wait_valid("rd");
    chk("rd_ipc", 64'(instr_pc), 64'h3A5);

    // Redirect during the handshake, to the top address, then wrap.
    redirect_valid = 1'b1;
    redirect_pc    = 10'h3FF;
    step();
    redirect_valid = 1'b0;
    chk("top_addr", 64'(mem_addr), 64'h3FF);
    wait_valid("top");
    chk("top_ipc", 64'(instr_pc), 64'h3FF);
    step();
    chk("wrap_addr", 64'(mem_addr), 64'd0);

    // Halt requested on beat 0: the instruction still completes.
    halt_req = 1'b1;
    wait_valid("halt");
    chk("halt_ipc", 64'(instr_pc), 64'd0);
    step();
    chk("halt_h", 64'(halted), 64'd1);
    chk("halt_req_o", 64'(mem_req), 64'd0);
    repeat (2) step();
    halt_req = 1'b0;
    step();
    chk("resume_req", 64'(mem_req), 64'd1);
    chk("resume_addr", 64'(mem_addr), 64'd1);

    // Reset while an instruction is presented.
    instr_ready = 1'b0;
    wait_valid("rst");
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rst_valid", 64'(instr_valid), 64'd0);
    chk("rst_addr", 64'(mem_addr), 64'd0);
    instr_ready = 1'b1;

    // Random traffic.
    mem_hash = 1'b1;
    for (int c = 0; c < 4000; c++) begin
      mem_valid      = ($urandom_range(0, 3) != 0);
      instr_ready    = ($urandom_range(0, 9) < 7);
      redirect_valid = ($urandom_range(0, 99) < 4);
      redirect_pc    = 10'($urandom);
      if ($urandom_range(0, 19) == 0) halt_req = ~halt_req;
      rst = ($urandom_range(0, 199) == 0);
      step();
    end
    rst            = 1'b0;
    redirect_valid = 1'b0;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
